// File: rtl/add_accum_unit.sv
// add_accum_unit: registered add/sub/accumulate/load unit with valid/ready
// handshakes, optional unsigned saturation and a pacing tick divider.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ena             global enable; low freezes all state
//   a, b, mode      operands and op (00 ADD, 01 SUB, 10 ACC, 11 LOAD)
//   in_valid/ready  input handshake
//   out_valid/ready output handshake
//   result          registered result
//   carry, sat      carry/borrow flag, clamp flag
//   acc_zero        accumulator is zero
//   tick            pacing pulse every TICK_DIV enabled cycles
module add_accum_unit #(
  parameter int WIDTH    = 8,
  parameter int SAT_EN   = 0,
  parameter int TICK_DIV = 10_000_000,
  parameter int PACED    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             sat,
  output logic             acc_zero,
  output logic             tick
);

  localparam int CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'(TICK_DIV - 1);
  localparam logic SAT   = (SAT_EN != 0);
  localparam logic PACE  = (PACED != 0);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;

  logic accept;
  logic drain;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic [WIDTH:0] asum;

  logic is_add;
  logic is_sub;
  logic is_acc;
  logic is_load;

  logic [WIDTH-1:0] nxt_res;
  logic             nxt_c;
  logic             nxt_s;
  logic             acc_we;

  assign tick     = (cnt == TLAST);
  assign in_ready = ena
                  & (~out_valid | out_ready)
                  & (~PACE | tick);
  assign accept   = in_valid & in_ready;
  assign drain    = ena & out_valid & out_ready;
  assign acc_zero = (acc == '0);

  assign sum  = {1'b0, a} + {1'b0, b};
  assign dif  = {1'b0, a} - {1'b0, b};
  assign asum = {1'b0, acc} + {1'b0, a};

  assign is_add  = (mode == 2'b00);
  assign is_sub  = (mode == 2'b01);
  assign is_acc  = (mode == 2'b10);
  assign is_load = (mode == 2'b11);

  always_comb begin
    nxt_res = '0;
    nxt_c   = 1'b0;
    nxt_s   = 1'b0;
    acc_we  = 1'b0;
    unique case (1'b1)
      is_add: begin
        nxt_c   = sum[WIDTH];
        nxt_s   = SAT & sum[WIDTH];
        nxt_res = nxt_s ? '1 : sum[WIDTH-1:0];
      end
      is_sub: begin
        // top bit of the widened difference is the borrow
        nxt_c   = dif[WIDTH];
        nxt_s   = SAT & dif[WIDTH];
        nxt_res = nxt_s ? '0 : dif[WIDTH-1:0];
      end
      is_acc: begin
        nxt_c   = asum[WIDTH];
        nxt_s   = SAT & asum[WIDTH];
        nxt_res = nxt_s ? '1 : asum[WIDTH-1:0];
        acc_we  = 1'b1;
      end
      is_load: begin
        nxt_res = b;
        acc_we  = 1'b1;
      end
      default: begin
        nxt_res = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (ena) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      if (accept) begin
        result    <= nxt_res;
        carry     <= nxt_c;
        sat       <= nxt_s;
        out_valid <= 1'b1;
        // acc follows the (possibly clamped) result
        if (acc_we) begin
          acc <= nxt_res;
        end
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_accum_unit.sv
// tb_add_accum_unit: directed bench for add_accum_unit
// wrap, saturating and paced variants
module tb_add_accum_unit;

  logic       clk = 1'b0;
  logic       rst, ena, iv, ordy;
  logic [7:0] a, b;
  logic [1:0] mode;

  logic       p_rst, p_ena, p_iv, p_ordy;
  logic [7:0] p_a, p_b;
  logic [1:0] p_mode;

  logic       w_ir, w_ov, w_c, w_s, w_z, w_t;
  logic [7:0] w_r;
  logic       s_ir, s_ov, s_c, s_s, s_z, s_t;
  logic [7:0] s_r;
  logic       p_ir, p_ov, p_c, p_s, p_z, p_t;
  logic [7:0] p_r;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  add_accum_unit #(.WIDTH(8), .SAT_EN(0))
  u_wrap (
    .clk(clk), .rst(rst), .ena(ena),
    .a(a), .b(b), .mode(mode),
    .in_valid(iv), .in_ready(w_ir),
    .out_valid(w_ov), .out_ready(ordy),
    .result(w_r), .carry(w_c), .sat(w_s),
    .acc_zero(w_z), .tick(w_t)
  );

  add_accum_unit #(.WIDTH(8), .SAT_EN(1))
  u_sat (
    .clk(clk), .rst(rst), .ena(ena),
    .a(a), .b(b), .mode(mode),
    .in_valid(iv), .in_ready(s_ir),
    .out_valid(s_ov), .out_ready(ordy),
    .result(s_r), .carry(s_c), .sat(s_s),
    .acc_zero(s_z), .tick(s_t)
  );

  add_accum_unit #(
    .WIDTH(8), .SAT_EN(0),
    .TICK_DIV(4), .PACED(1)
  ) u_pace (
    .clk(clk), .rst(p_rst), .ena(p_ena),
    .a(p_a), .b(p_b), .mode(p_mode),
    .in_valid(p_iv), .in_ready(p_ir),
    .out_valid(p_ov), .out_ready(p_ordy),
    .result(p_r), .carry(p_c), .sat(p_s),
    .acc_zero(p_z), .tick(p_t)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m,
                       input logic [7:0] xa,
                       input logic [7:0] xb);
    mode = m;
    a    = xa;
    b    = xb;
    iv   = 1'b1;
  endtask

  // both flavours checked after one op
  task automatic op2(input string tag,
                     input logic [1:0] m,
                     input logic [7:0] xa,
                     input logic [7:0] xb,
                     input logic [7:0] wr,
                     input logic       wc,
                     input logic [7:0] sr,
                     input logic       sc,
                     input logic       ss);
    drive(m, xa, xb);
    cyc();
    chk({tag, "_w_res"}, w_r, wr);
    chk({tag, "_w_c"},   w_c, wc);
    chk({tag, "_w_sat"}, w_s, 1'b0);
    chk({tag, "_w_ov"},  w_ov, 1'b1);
    chk({tag, "_s_res"}, s_r, sr);
    chk({tag, "_s_c"},   s_c, sc);
    chk({tag, "_s_sat"}, s_s, ss);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; iv = 1'b0;
    ordy = 1'b1; a = '0; b = '0; mode = '0;
    p_rst = 1'b1; p_ena = 1'b1; p_iv = 1'b0;
    p_ordy = 1'b1; p_a = '0; p_b = '0;
    p_mode = 2'b00;

    cyc();
    cyc();
    chk("rst_res",  w_r, 8'h00);
    chk("rst_c",    w_c, 1'b0);
    chk("rst_ov",   w_ov, 1'b0);
    chk("rst_z",    w_z, 1'b1);
    chk("rst_sat",  s_s, 1'b0);
    chk("rst_sov",  s_ov, 1'b0);

    rst = 1'b0;
    drive(2'b00, 8'h7F, 8'h01);
    #1;
    chk("ir_idle", w_ir, 1'b1);
    cyc();
    chk("add1_res", w_r, 8'h80);
    chk("add1_c",   w_c, 1'b0);
    chk("add1_ov",  w_ov, 1'b1);

    op2("addff", 2'b00, 8'hFF, 8'h02,
        8'h01, 1'b1, 8'hFF, 1'b1, 1'b1);
    op2("addf0", 2'b00, 8'hF0, 8'h20,
        8'h10, 1'b1, 8'hFF, 1'b1, 1'b1);
    op2("sub59", 2'b01, 8'h05, 8'h09,
        8'hFC, 1'b1, 8'h00, 1'b1, 1'b1);
    op2("sub95", 2'b01, 8'h09, 8'h05,
        8'h04, 1'b0, 8'h04, 1'b0, 1'b0);
    chk("addsub_acc_z", w_z, 1'b1);

    op2("ld10", 2'b11, 8'hAA, 8'h10,
        8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
    chk("ld10_z", w_z, 1'b0);
    op2("acc1", 2'b10, 8'h05, 8'hEE,
        8'h15, 1'b0, 8'h15, 1'b0, 1'b0);
    op2("acc2", 2'b10, 8'h05, 8'h00,
        8'h1A, 1'b0, 8'h1A, 1'b0, 1'b0);
    op2("acc3", 2'b10, 8'h05, 8'h77,
        8'h1F, 1'b0, 8'h1F, 1'b0, 1'b0);
    op2("ld00", 2'b11, 8'h33, 8'h00,
        8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("ld00_wz", w_z, 1'b1);
    chk("ld00_sz", s_z, 1'b1);

    op2("ldf0", 2'b11, 8'h00, 8'hF0,
        8'hF0, 1'b0, 8'hF0, 1'b0, 1'b0);
    op2("accov", 2'b10, 8'h20, 8'h00,
        8'h10, 1'b1, 8'hFF, 1'b1, 1'b1);
    op2("accst", 2'b10, 8'h01, 8'h00,
        8'h11, 1'b0, 8'hFF, 1'b1, 1'b1);

    drive(2'b00, 8'h01, 8'h02);
    cyc();
    chk("bp_first", w_r, 8'h03);
    ordy = 1'b0;
    drive(2'b10, 8'hAA, 8'h11);
    #1;
    chk("bp_ir", w_ir, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_res",  w_r, 8'h03);
      chk("bp_ov",   w_ov, 1'b1);
      chk("bp_ir_h", w_ir, 1'b0);
    end

    ordy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(2'b00, 8'(i * 3), 8'h01);
      #1;
      chk("tp_ir", w_ir, 1'b1);
      cyc();
      chk("tp_res", w_r, 8'(i * 3 + 1));
      chk("tp_ov",  w_ov, 1'b1);
    end
    chk("tp_acc", w_r + 8'h00, 8'h0D);

    iv = 1'b0;
    cyc();
    chk("drain_ov",  w_ov, 1'b0);
    chk("drain_res", w_r, 8'h0D);

    drive(2'b00, 8'h20, 8'h22);
    ena = 1'b0;
    #1;
    chk("ena0_ir", w_ir, 1'b0);
    cyc();
    chk("ena0_ov",  w_ov, 1'b0);
    chk("ena0_res", w_r, 8'h0D);
    ena = 1'b1;
    cyc();
    chk("ena1_res", w_r, 8'h42);
    chk("ena1_ov",  w_ov, 1'b1);
    iv = 1'b0;
    ena = 1'b0;
    cyc();
    chk("ena0_hold", w_ov, 1'b1);
    ena = 1'b1;
    cyc();
    chk("ena1_drn", w_ov, 1'b0);

    drive(2'b11, 8'h00, 8'h33);
    cyc();
    chk("pre_rst_z", w_z, 1'b0);
    chk("pre_rst_ov", w_ov, 1'b1);
    iv = 1'b0;
    ordy = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_ov",  w_ov, 1'b0);
    chk("mrst_res", w_r, 8'h00);
    chk("mrst_z",   w_z, 1'b1);
    chk("mrst_c",   w_c, 1'b0);

    // paced unit: ticks at 3,7,11; ena low on 13,14
    // pushes the next one to 17; reset on 20 gives 24
    p_rst = 1'b0;
    p_iv  = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      logic et;
      logic en;
      logic rs;
      et = (k == 3 || k == 7 || k == 11 ||
            k == 17 || k == 24);
      en = !(k == 13 || k == 14);
      rs = (k == 20);
      p_ena = en;
      p_rst = rs;
      p_a   = 8'(k);
      #1;
      chk("p_tick", p_t, et);
      chk("p_ir",   p_ir, et & en);
      cyc();
      p_rst = 1'b0;
      chk("p_ov", p_ov, et & en & !rs);
      if (et & en)
        chk("p_res", p_r, 8'(k));
      if (rs)
        chk("p_rst_res", p_r, 8'h00);
    end
    p_iv = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
